// File: rtl/instr_queue_splitter_pkg.sv
// -----------------------------------------------------------------------------
// instr_queue_splitter_pkg
//   Shared definitions for the instruction queue splitter: SoftMC opcode field
//   geometry, the END_ISEQ opcode that releases a buffered sequence, and the
//   FILL/EXEC state encoding.
// -----------------------------------------------------------------------------
package instr_queue_splitter_pkg;

  // Opcode occupies the top OPC_W bits of every instruction.
  localparam int OPC_W = 4;

  // Terminates a host instruction sequence; never stored in a queue.
  localparam logic [OPC_W-1:0] END_ISEQ = 4'b0000;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage : instr_queue_splitter_pkg

// File: rtl/instr_queue_splitter_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
//   Synchronous first-word-fall-through FIFO. The head entry is always visible
//   on dout while empty is low; a write becomes visible one cycle later.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   wr_en, din   write request / data (ignored while full)
//   full         no free entry
//   rd_en        pop the head entry (ignored while empty)
//   dout         head entry
//   empty        no valid entry
//   count        number of stored entries (0 .. 2^QDEPTH_LOG2)
// -----------------------------------------------------------------------------
module instr_fifo #(
  parameter int INSTR_W     = 32,
  parameter int QDEPTH_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [INSTR_W-1:0]     din,
  output logic                   full,
  input  logic                   rd_en,
  output logic [INSTR_W-1:0]     dout,
  output logic                   empty,
  output logic [QDEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << QDEPTH_LOG2;

  logic [INSTR_W-1:0]     mem_q [DEPTH];
  logic [QDEPTH_LOG2-1:0] wr_ptr_q;
  logic [QDEPTH_LOG2-1:0] rd_ptr_q;
  logic [QDEPTH_LOG2:0]   count_q;
  logic                   do_wr_s;
  logic                   do_rd_s;

  // Count is one bit wider than the pointers so full and empty differ.
  assign full    = count_q[QDEPTH_LOG2];
  assign empty   = (count_q == {(QDEPTH_LOG2+1){1'b0}});
  assign count   = count_q;
  assign do_wr_s = wr_en & ~full;
  assign do_rd_s = rd_en & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {QDEPTH_LOG2{1'b0}};
      rd_ptr_q <= {QDEPTH_LOG2{1'b0}};
      count_q  <= {(QDEPTH_LOG2+1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_q <= wr_ptr_q + QDEPTH_LOG2'(1);
      end
      if (do_rd_s) begin
        rd_ptr_q <= rd_ptr_q + QDEPTH_LOG2'(1);
      end
      count_q <= count_q + {{QDEPTH_LOG2{1'b0}}, do_wr_s}
                         - {{QDEPTH_LOG2{1'b0}}, do_rd_s};
    end
  end

endmodule : instr_fifo

// File: rtl/instr_queue_splitter.sv
// -----------------------------------------------------------------------------
// instr_queue_splitter
//   Buffers a host SoftMC instruction sequence and splits it round-robin into
//   two FWFT queues feeding the two-slot dispatcher. In FILL the sequence is
//   accumulated; an END instruction (with something queued) switches to EXEC,
//   where both queue heads are presented until fully drained, after which the
//   block re-arms in FILL with the write select back on queue 0.
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   host_valid/ready/instr   host instruction stream
//   en_out0/instr_out0       queue 0 head to dispatcher slot 0; ack_in0 pops
//   en_out1/instr_out1       queue 1 head to dispatcher slot 1; ack_in1 pops
//   busy                     high while in EXEC
//   iseq_done                one-cycle pulse after EXEC has drained
// -----------------------------------------------------------------------------
module instr_queue_splitter
  import instr_queue_splitter_pkg::*;
#(
  parameter int QDEPTH_LOG2 = 10,
  parameter int INSTR_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [INSTR_W-1:0] host_instr,
  output logic               en_out0,
  output logic [INSTR_W-1:0] instr_out0,
  input  logic               ack_in0,
  output logic               en_out1,
  output logic [INSTR_W-1:0] instr_out1,
  input  logic               ack_in1,
  output logic               busy,
  output logic               iseq_done
);

  state_e               state_q;
  state_e               state_d;
  logic                 wsel_q;
  logic                 wsel_d;
  logic                 done_q;
  logic                 done_d;
  logic                 armed_q;

  logic                 full0_s;
  logic                 full1_s;
  logic                 empty0_s;
  logic                 empty1_s;
  logic [QDEPTH_LOG2:0] count0_s;
  logic [QDEPTH_LOG2:0] count1_s;

  logic                 is_end_s;
  logic                 accept_s;
  logic                 wr0_s;
  logic                 wr1_s;
  logic                 pop0_s;
  logic                 pop1_s;
  logic                 drained0_s;
  logic                 drained1_s;

  assign is_end_s = (host_instr[INSTR_W-1 -: OPC_W] == END_ISEQ);

  // armed_q keeps host_ready low while rst_n is asserted and for the first
  // cycle after release, so nothing is accepted out of reset.
  assign host_ready = armed_q & (state_q == ST_FILL) & ~(wsel_q ? full1_s : full0_s);
  assign accept_s   = host_valid & host_ready;

  // END is consumed but never stored; other opcodes go to the selected queue.
  assign wr0_s = accept_s & ~is_end_s & ~wsel_q;
  assign wr1_s = accept_s & ~is_end_s &  wsel_q;

  assign busy    = (state_q == ST_EXEC);
  assign en_out0 = busy & ~empty0_s;
  assign en_out1 = busy & ~empty1_s;

  // ack_in* idles high, so a pop needs both the enable and the ack.
  assign pop0_s = en_out0 & ack_in0;
  assign pop1_s = en_out1 & ack_in1;

  // A queue is drained after this cycle if already empty or popping its last entry.
  assign drained0_s = empty0_s | (pop0_s & (count0_s == (QDEPTH_LOG2+1)'(1)));
  assign drained1_s = empty1_s | (pop1_s & (count1_s == (QDEPTH_LOG2+1)'(1)));

  assign iseq_done = done_q;

  instr_fifo #(
    .INSTR_W     (INSTR_W),
    .QDEPTH_LOG2 (QDEPTH_LOG2)
  ) u_q0 (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr0_s),
    .din   (host_instr),
    .full  (full0_s),
    .rd_en (pop0_s),
    .dout  (instr_out0),
    .empty (empty0_s),
    .count (count0_s)
  );

  instr_fifo #(
    .INSTR_W     (INSTR_W),
    .QDEPTH_LOG2 (QDEPTH_LOG2)
  ) u_q1 (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr1_s),
    .din   (host_instr),
    .full  (full1_s),
    .rd_en (pop1_s),
    .dout  (instr_out1),
    .empty (empty1_s),
    .count (count1_s)
  );

  // Next-state logic for the FILL/EXEC sequence controller.
  always_comb begin
    state_d = state_q;
    wsel_d  = wsel_q;
    done_d  = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept_s) begin
          if (is_end_s) begin
            // An END with nothing buffered is dropped.
            if (!(empty0_s & empty1_s)) begin
              state_d = ST_EXEC;
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            wsel_d = ~wsel_q;
          end
        end else begin
          wsel_d = wsel_q;
        end
      end
      ST_EXEC: begin
        if (drained0_s & drained1_s) begin
          // Back to slot 0, matching the dispatcher's slot-swap reset.
          state_d = ST_FILL;
          wsel_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      default: begin
        state_d = ST_FILL;
        wsel_d  = 1'b0;
      end
    endcase
  end

  // Controller state, write select, done pulse and post-reset arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      wsel_q  <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wsel_q  <= wsel_d;
      done_q  <= done_d;
      armed_q <= 1'b1;
    end
  end

endmodule : instr_queue_splitter

// File: tb/tb_instr_queue_splitter.sv
// -----------------------------------------------------------------------------
// tb_instr_queue_splitter
//   Directed bench for instr_queue_splitter with 4-entry queues. Inputs change
//   1 time unit after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_instr_queue_splitter;
  import instr_queue_splitter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        host_valid;
  logic        host_ready;
  logic [31:0] host_instr;
  logic        en_out0;
  logic [31:0] instr_out0;
  logic        ack_in0;
  logic        en_out1;
  logic [31:0] instr_out1;
  logic        ack_in1;
  logic        busy;
  logic        iseq_done;

  int n_chk;
  int n_bad;

  localparam logic [31:0] END_W = 32'h0000_0000;
  localparam logic [31:0] I_A   = 32'h1000_00A0;
  localparam logic [31:0] I_B   = 32'h2000_00B0;
  localparam logic [31:0] I_C   = 32'h3000_00C0;
  localparam logic [31:0] I_X   = 32'h4000_0011;
  localparam logic [31:0] I_Y   = 32'h5000_0022;

  instr_queue_splitter #(
    .QDEPTH_LOG2 (2),
    .INSTR_W     (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_instr (host_instr),
    .en_out0    (en_out0),
    .instr_out0 (instr_out0),
    .ack_in0    (ack_in0),
    .en_out1    (en_out1),
    .instr_out1 (instr_out1),
    .ack_in1    (ack_in1),
    .busy       (busy),
    .iseq_done  (iseq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for exactly one clock edge.
  task automatic send(input logic [31:0] w);
    host_valid = 1'b1;
    host_instr = w;
    tick();
    host_valid = 1'b0;
  endtask

  initial begin
    n_chk      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    host_valid = 1'b0;
    host_instr = 32'h0000_0000;
    ack_in0    = 1'b0;
    ack_in1    = 1'b0;

    // Reset state
    #3;
    chk("rst_ready", 32'(host_ready), 32'd0);
    chk("rst_en0",   32'(en_out0),    32'd0);
    chk("rst_en1",   32'(en_out1),    32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_done",  32'(iseq_done),  32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // END with both queues empty is discarded
    chk("t2_ready_pre", 32'(host_ready), 32'd1);
    send(END_W);
    chk("t2_busy",  32'(busy),      32'd0);
    chk("t2_ready", 32'(host_ready), 32'd1);
    chk("t2_done",  32'(iseq_done), 32'd0);
    tick();
    chk("t2_busy2", 32'(busy),      32'd0);
    chk("t2_done2", 32'(iseq_done), 32'd0);

    // A,B,C,END -> q0={A,C}, q1={B}
    send(I_A); send(I_B); send(I_C); send(END_W);
    chk("t1_en0",   32'(en_out0),    32'd1);
    chk("t1_head0", instr_out0,      I_A);
    chk("t1_en1",   32'(en_out1),    32'd1);
    chk("t1_head1", instr_out1,      I_B);
    chk("t1_busy",  32'(busy),       32'd1);
    chk("t1_ready", 32'(host_ready), 32'd0);

    // Pop q0 only, then q1
    ack_in0 = 1'b1;
    tick();
    chk("t3_en0_a",   32'(en_out0),   32'd1);
    chk("t3_head0_c", instr_out0,     I_C);
    chk("t3_done_a",  32'(iseq_done), 32'd0);
    tick();
    chk("t3_en0_b",   32'(en_out0),   32'd0);
    chk("t3_en1_b",   32'(en_out1),   32'd1);
    chk("t3_head1_b", instr_out1,     I_B);
    chk("t3_busy_b",  32'(busy),      32'd1);
    chk("t3_done_b",  32'(iseq_done), 32'd0);
    ack_in1 = 1'b1;
    tick();
    chk("t3_done_c",  32'(iseq_done), 32'd1);
    chk("t3_busy_c",  32'(busy),      32'd0);
    chk("t3_en1_c",   32'(en_out1),   32'd0);
    ack_in0 = 1'b0;
    ack_in1 = 1'b0;
    tick();
    chk("t3_done_d",  32'(iseq_done), 32'd0);
    chk("t3_ready_d", 32'(host_ready), 32'd1);

    // After an odd-length sequence, X must land in q0
    send(I_X); send(I_Y); send(END_W);
    chk("t5_en0",   32'(en_out0), 32'd1);
    chk("t5_head0", instr_out0,   I_X);
    chk("t5_en1",   32'(en_out1), 32'd1);
    chk("t5_head1", instr_out1,   I_Y);
    ack_in0 = 1'b1;
    ack_in1 = 1'b1;
    tick();
    chk("t5_done", 32'(iseq_done), 32'd1);
    chk("t5_busy", 32'(busy),      32'd0);
    chk("t5_en0b", 32'(en_out0),   32'd0);
    ack_in0 = 1'b0;
    ack_in1 = 1'b0;
    tick();

    // Fill both 4-entry queues; q0 full stalls the host
    for (int i = 0; i < 8; i++) begin
      chk("t4_ready_w", 32'(host_ready), 32'd1);
      send(32'h6000_0000 + 32'(i));
    end
    chk("t4_ready_full", 32'(host_ready), 32'd0);
    host_valid = 1'b1;
    host_instr = 32'h6000_0009;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_ready_hold", 32'(host_ready), 32'd0);
      chk("t4_busy_hold",  32'(busy),       32'd0);
    end
    host_instr = END_W;
    tick();
    chk("t4_end_ready", 32'(host_ready), 32'd0);
    chk("t4_end_busy",  32'(busy),       32'd0);
    host_valid = 1'b0;

    // Reset discards the full queues
    rst_n = 1'b0;
    #1;
    chk("t4_rst_ready", 32'(host_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t4_post_ready", 32'(host_ready), 32'd1);
    send(END_W);
    chk("t4_post_busy", 32'(busy), 32'd0);

    // Reset in the middle of EXEC
    send(I_A); send(I_B); send(I_C); send(END_W);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_en0",   32'(en_out0),    32'd0);
    chk("t6_en1",   32'(en_out1),    32'd0);
    chk("t6_busy",  32'(busy),       32'd0);
    chk("t6_ready", 32'(host_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    send(END_W);
    chk("t6_end_busy",  32'(busy),       32'd0);
    chk("t6_end_ready", 32'(host_ready), 32'd1);
    chk("t6_end_en0",   32'(en_out0),    32'd0);
    tick();
    chk("t6_end_done",  32'(iseq_done),  32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_instr_queue_splitter
